// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types for the cache read-port arbiter: FSM states, AXI response codes
// and the grant-index width helper.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  // Grant index width; a single requester still needs one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Requester-side (req_*) and system-side (m_*) AR/R signals of the read arbiter.
// The arbiter uses the slave modport; the environment uses master.
interface axi_rd_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
);
  logic [NUM_REQ-1:0]                req_arvalid;
  logic [NUM_REQ-1:0][ADDR_SIZE-1:0] req_araddr;
  logic [NUM_REQ-1:0][7:0]           req_arlen;
  logic [NUM_REQ-1:0]                req_arready;
  logic [NUM_REQ-1:0]                req_rvalid;
  logic [DATA_SIZE-1:0]              req_rdata;
  logic [1:0]                        req_rresp;
  logic                              req_rlast;
  logic [NUM_REQ-1:0]                req_rready;

  logic                 m_arvalid;
  logic [ADDR_SIZE-1:0] m_araddr;
  logic [7:0]           m_arlen;
  logic                 m_arready;
  logic                 m_rvalid;
  logic [DATA_SIZE-1:0] m_rdata;
  logic [1:0]           m_rresp;
  logic                 m_rlast;
  logic                 m_rready;

  modport slave (
    input  req_arvalid, req_araddr, req_arlen, req_rready,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    output req_arready, req_rvalid, req_rdata, req_rresp, req_rlast,
           m_arvalid, m_araddr, m_arlen, m_rready
  );

  modport master (
    output req_arvalid, req_araddr, req_arlen, req_rready,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    input  req_arready, req_rvalid, req_rdata, req_rresp, req_rlast,
           m_arvalid, m_araddr, m_arlen, m_rready
  );
endinterface

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request bit searching upward from ptr+1.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int GRANT_W = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] grant,
  output logic               any
);

  int idx;

  // Walk the search order backwards so the earliest candidate is written last.
  always_comb begin
    grant = '0;
    any   = |req;
    idx   = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[GRANT_W'(idx)]) grant = GRANT_W'(idx);
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin sharing of one AXI4 read port between NUM_REQ cache masters,
// one burst in flight, with beat-count checking against ARLEN.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                i_aclk,
  input  logic                i_areset_n,
  axi_rd_arbiter_if.slave     bus,
  output logic                o_busy,
  output logic                o_proto_err
);

  localparam int GRANT_W = grant_w(NUM_REQ);

  arb_state_t           state, state_d;
  logic [GRANT_W-1:0]   ptr, gnt_q, pick;
  logic                 pick_any;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [7:0]           len_q;
  logic [8:0]           beat_cnt;
  logic                 r_hs;
  logic [NUM_REQ-1:0]   arready_v, rvalid_v;

  rr_pick #(.NUM_REQ(NUM_REQ), .GRANT_W(GRANT_W)) u_pick (
    .req   (bus.req_arvalid),
    .ptr   (ptr),
    .grant (pick),
    .any   (pick_any)
  );

  always_ff @(posedge i_aclk) begin
    if (!i_areset_n) begin
      state    <= IDLE;
      ptr      <= GRANT_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (pick_any) begin
          gnt_q  <= pick;
          addr_q <= bus.req_araddr[pick];
          len_q  <= bus.req_arlen[pick];
        end
        ADDR: if (bus.m_arready) beat_cnt <= '0;
        DATA: if (r_hs) begin
          beat_cnt <= beat_cnt + 9'd1;
          if (bus.m_rlast) ptr <= gnt_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state;
    bus.m_rready = 1'b0;
    r_hs         = 1'b0;
    o_proto_err  = 1'b0;
    case (state)
      IDLE: if (pick_any) state_d = ADDR;
      ADDR: if (bus.m_arready) state_d = DATA;
      DATA: begin
        bus.m_rready = bus.req_rready[gnt_q];
        r_hs         = bus.m_rvalid & bus.req_rready[gnt_q];
        if (r_hs) begin
          if (bus.m_rlast) state_d = IDLE;
          // Early rlast, or the ARLEN-th beat arriving without rlast.
          o_proto_err = bus.m_rlast ? (beat_cnt != {1'b0, len_q})
                                    : (beat_cnt == {1'b0, len_q});
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Requester AR handshake completes in IDLE; held off while reset is asserted.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_route
    assign arready_v[k] = i_areset_n && (state == IDLE) && pick_any && (pick == GRANT_W'(k));
    assign rvalid_v[k]  = (state == DATA) && (gnt_q == GRANT_W'(k)) && bus.m_rvalid;
  end

  assign bus.req_arready = arready_v;
  assign bus.req_rvalid  = rvalid_v;
  assign bus.req_rdata   = (state == DATA) ? bus.m_rdata : '0;
  assign bus.req_rresp   = (state == DATA) ? bus.m_rresp : RESP_OKAY;
  assign bus.req_rlast   = (state == DATA) && bus.m_rlast;

  assign bus.m_arvalid = (state == ADDR);
  assign bus.m_araddr  = (state == ADDR) ? addr_q : '0;
  assign bus.m_arlen   = (state == ADDR) ? len_q  : '0;

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter (4 requesters): grant table plus
// backpressure, protocol-error and mid-burst reset sequences.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, perr;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

  axi_rd_arbiter #(.NUM_REQ(NR), .ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .i_aclk      (clk),
    .i_areset_n  (rst_n),
    .bus         (bus.slave),
    .o_busy      (busy),
    .o_proto_err (perr)
  );

  typedef struct {
    logic [NR-1:0] mask;
    int            g;
    logic [7:0]    len;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR-1:0] oh(input int g);
    return NR'(1) << g;
  endfunction

  function automatic logic [AW-1:0] adr(input int g);
    return AW'(g + 1) << 12;
  endfunction

  // Requester handshake in IDLE, then the AR phase with `stall` cycles of backpressure.
  task automatic start(input logic [NR-1:0] mask, input int g, input logic [7:0] len, input int stall);
    bus.req_arvalid = mask;
    bus.req_araddr  = {adr(3), adr(2), adr(1), adr(0)};
    bus.req_arlen   = {NR{len}};
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_perr", 64'(perr), 64'(0));
    chk("grant", 64'(bus.req_arready), 64'(oh(g)));
    cyc();
    bus.m_rvalid   = 1'b1;
    bus.req_rready = '1;
    for (int i = 0; i <= stall; i++) begin
      bus.m_arready = (i == stall);
      @(negedge clk);
      chk("ar_valid", 64'(bus.m_arvalid), 64'(1));
      chk("ar_addr", 64'(bus.m_araddr), 64'(adr(g)));
      chk("ar_len", 64'(bus.m_arlen), 64'(len));
      chk("ar_ready_busy", 64'(bus.req_arready), 64'(0));
      chk("r_blocked", 64'({bus.m_rready, bus.req_rvalid}), 64'(0));
      cyc();
    end
    bus.m_arready   = 1'b0;
    bus.m_rvalid    = 1'b0;
    bus.req_arvalid = '0;
  endtask

  // One R cycle; other requesters always show rready=1 to prove isolation.
  task automatic beat(input int g, input logic last, input logic rdy, input logic err);
    logic [DW-1:0] d;
    logic [1:0]    rs;
    d  = $urandom;
    rs = 2'($urandom_range(0, 3));
    bus.m_rvalid   = 1'b1;
    bus.m_rdata    = d;
    bus.m_rresp    = rs;
    bus.m_rlast    = last;
    bus.req_rready = ~oh(g) | (rdy ? oh(g) : '0);
    @(negedge clk);
    chk("r_valid", 64'(bus.req_rvalid), 64'(oh(g)));
    chk("r_data", 64'(bus.req_rdata), 64'(d));
    chk("r_resp", 64'(bus.req_rresp), 64'(rs));
    chk("r_last", 64'(bus.req_rlast), 64'(last));
    chk("m_rready", 64'(bus.m_rready), 64'(rdy));
    chk("proto_err", 64'(perr), 64'(err));
    cyc();
    bus.m_rvalid   = 1'b0;
    bus.m_rlast    = 1'b0;
    bus.req_rready = '0;
  endtask

  initial begin
    tbl[0] = '{4'b0011, 0, 8'd3};
    tbl[1] = '{4'b0011, 1, 8'd1};
    tbl[2] = '{4'b0011, 0, 8'd0};
    tbl[3] = '{4'b0011, 1, 8'd0};
    tbl[4] = '{4'b1010, 3, 8'd2};
    tbl[5] = '{4'b1010, 1, 8'd0};
    tbl[6] = '{4'b0100, 2, 8'd0};
    tbl[7] = '{4'b1111, 3, 8'd1};
    tbl[8] = '{4'b1111, 0, 8'd0};

    bus.req_arvalid = '0;
    bus.req_araddr  = '0;
    bus.req_arlen   = '0;
    bus.req_rready  = '0;
    bus.m_arready   = 1'b0;
    bus.m_rvalid    = 1'b0;
    bus.m_rdata     = '0;
    bus.m_rresp     = '0;
    bus.m_rlast     = 1'b0;

    repeat (2) cyc();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_outs", 64'({bus.req_arready, bus.req_rvalid, bus.m_arvalid, bus.m_rready, perr}), 64'(0));
    cyc();
    rst_n = 1'b1;

    // Grant order and single-beat / multi-beat bursts, back to back.
    foreach (tbl[i]) begin
      start(tbl[i].mask, tbl[i].g, tbl[i].len, 0);
      for (int b = 0; b <= int'(tbl[i].len); b++)
        beat(tbl[i].g, b == int'(tbl[i].len), 1'b1, 1'b0);
    end

    // AR stall for 5 cycles, then rready toggling on the owner.
    start(4'b0100, 2, 8'd2, 5);
    beat(2, 1'b0, 1'b1, 1'b0);
    beat(2, 1'b0, 1'b0, 1'b0);
    beat(2, 1'b0, 1'b1, 1'b0);
    beat(2, 1'b1, 1'b0, 1'b0);
    beat(2, 1'b1, 1'b1, 1'b0);

    // Early rlast on beat 2 of 4.
    start(4'b0001, 0, 8'd3, 0);
    beat(0, 1'b0, 1'b1, 1'b0);
    beat(0, 1'b1, 1'b1, 1'b1);

    // arlen=1 without rlast on beat 2; burst runs on until rlast.
    start(4'b0010, 1, 8'd1, 0);
    beat(1, 1'b0, 1'b1, 1'b0);
    beat(1, 1'b0, 1'b1, 1'b1);
    beat(1, 1'b0, 1'b1, 1'b0);
    beat(1, 1'b1, 1'b1, 1'b1);

    // Reset after 1 of 4 beats.
    start(4'b0001, 0, 8'd3, 0);
    beat(0, 1'b0, 1'b1, 1'b0);
    bus.req_arvalid = '1;
    bus.req_rready  = '1;
    bus.m_rvalid    = 1'b1;
    bus.m_rdata     = '1;
    bus.m_rresp     = 2'(RESP_SLVERR);
    bus.m_rlast     = 1'b1;
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ctl", 64'({bus.req_arready, bus.req_rvalid, bus.m_arvalid, bus.m_rready, bus.req_rlast, perr}), 64'(0));
    chk("mid_rst_addr", 64'({bus.m_araddr, bus.m_arlen}), 64'(0));
    chk("mid_rst_data", 64'({bus.req_rdata, bus.req_rresp}), 64'(0));
    cyc();
    rst_n = 1'b1;
    bus.req_rready = '0;
    bus.m_rvalid   = 1'b0;
    bus.m_rlast    = 1'b0;
    bus.m_rresp    = '0;
    // Pointer back at NUM_REQ-1: requester 0 wins with everyone requesting.
    start(4'b1111, 0, 8'd0, 0);
    beat(0, 1'b1, 1'b1, 1'b0);

    @(negedge clk);
    chk("end_busy", 64'(busy), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
